serial_bit_feeder: RTL and testbench

- Upstream stage of the sequence-detector FSM. It accepts parallel words over a valid/ready handshake and drives them out one bit per clock on the detector's serial input w.
- A one-entry holding register is included, so back-to-back words stream with no idle gap.
- When no data is available, w is held at a fixed idle level so the detector sees a defined input on every clock.

---
 rtl/serial_bit_feeder_pkg.sv | 19 +
 rtl/feeder_hold_reg.sv | 40 ++++
 rtl/serial_bit_feeder.sv | 131 +++++++++++++
 tb/tb_serial_bit_feeder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bit_feeder_pkg.sv
// Shared types and constants for the serial bit feeder and the sequence-detector benches.
package serial_bit_feeder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] PAT_1010 = 4'b1010;

  // Ceiling log2, at least 1 for any v >= 2.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/feeder_hold_reg.sv
// One-entry holding register: captures a word on load, frees the slot on unload.
module feeder_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (unload) full_d = 1'b0;
    if (load) begin
      data_d = din;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/serial_bit_feeder.sv
// Serialises parallel words onto the detector input w, one bit per clock, with a
// one-word holding slot so back-to-back words stream without an idle gap.
module serial_bit_feeder
  import serial_bit_feeder_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             w,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int unsigned    CW   = clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             w_q, w_d;
  logic             bit_valid_q, bit_valid_d;
  logic             last_bit_q, last_bit_d;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_load, hold_unload;
  logic             xfer, end_of_word, do_load, advance;
  logic [WIDTH-1:0] load_word, src;

  feeder_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk    (clk),
    .resetn (resetn),
    .load   (hold_load),
    .unload (hold_unload),
    .din    (din),
    .dout   (hold_data),
    .full   (hold_full)
  );

  assign load_ready  = !hold_full;
  assign xfer        = load_valid && load_ready;
  assign end_of_word = (state_q == ST_SHIFT) && (cnt_q == LAST);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    w_d         = w_q;
    hold_load   = 1'b0;
    hold_unload = 1'b0;
    do_load     = 1'b0;
    advance     = 1'b0;
    load_word   = din;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          do_load = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (end_of_word) begin
          // Held word has priority; with the slot empty a new word bypasses it.
          if (hold_full) begin
            do_load     = 1'b1;
            load_word   = hold_data;
            hold_unload = 1'b1;
          end else if (xfer) begin
            do_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          advance   = 1'b1;
          hold_load = xfer;
        end
      end
    endcase

    // shreg keeps only the bits still to be shown; w carries the current one.
    src = do_load ? load_word : shreg_q;
    if (do_load || advance) begin
      cnt_d = do_load ? '0 : cnt_q + 1'b1;
      if (LSB_FIRST) begin
        w_d     = src[0];
        shreg_d = src >> 1;
      end else begin
        w_d     = src[WIDTH-1];
        shreg_d = src << 1;
      end
    end else if (state_d == ST_IDLE) begin
      w_d   = IDLE_LEVEL;
      cnt_d = '0;
    end

    bit_valid_d = (state_d == ST_SHIFT);
    last_bit_d  = (state_d == ST_SHIFT) && (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      w_q         <= IDLE_LEVEL;
      bit_valid_q <= 1'b0;
      last_bit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      bit_valid_q <= bit_valid_d;
      last_bit_q  <= last_bit_d;
    end
  end

  assign w         = w_q;
  assign bit_valid = bit_valid_q;
  assign last_bit  = last_bit_q;
  assign busy      = (state_q == ST_SHIFT) || hold_full;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first/idle-0 and LSB-first/idle-1 instances share stimulus.
module tb_serial_bit_feeder;
  import serial_bit_feeder_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [7:0] din = '0;
  logic       load_valid = 1'b0;

  logic rdy0, w0, bv0, lb0, busy0;
  logic rdy1, w1, bv1, lb1, busy1;

  serial_bit_feeder #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .resetn(resetn), .din(din), .load_valid(load_valid),
    .load_ready(rdy0), .w(w0), .bit_valid(bv0), .last_bit(lb0), .busy(busy0));

  serial_bit_feeder #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .resetn(resetn), .din(din), .load_valid(load_valid),
    .load_ready(rdy1), .w(w1), .bit_valid(bv1), .last_bit(lb1), .busy(busy1));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a queue of (word, serial position) for every bit not yet shown.
  typedef struct {
    logic [7:0]  word;
    int unsigned pos;
  } mbit_t;
  mbit_t       pend[$];
  logic        cur_valid = 1'b0;
  logic [7:0]  cur_word  = '0;
  int unsigned cur_pos   = 0;

  typedef struct {
    logic       rn;
    logic       v;
    logic [7:0] d;
    logic       ew, ebv, elb, ebusy, erdy, pat;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic rn, input logic v, input logic [7:0] d,
                              input logic ew, input logic ebv, input logic elb,
                              input logic ebusy, input logic erdy, input logic pat);
    vec_t r;
    r.rn = rn; r.v = v; r.d = d; r.ew = ew; r.ebv = ebv;
    r.elb = elb; r.ebusy = ebusy; r.erdy = erdy; r.pat = pat;
    return r;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    return pend.size() < 8;
  endfunction

  task automatic model_clear();
    pend.delete();
    cur_valid = 1'b0;
  endtask

  task automatic model_cmp();
    logic e0, e1;
    e0 = cur_valid ? cur_word[7 - cur_pos] : 1'b0;
    e1 = cur_valid ? cur_word[cur_pos]     : 1'b1;
    chk("m_w0", w0, e0);
    chk("m_w1", w1, e1);
    chk("m_bv0", bv0, cur_valid);
    chk("m_bv1", bv1, cur_valid);
    chk("m_last0", lb0, cur_valid && (cur_pos == 7));
    chk("m_last1", lb1, cur_valid && (cur_pos == 7));
    chk("m_busy0", busy0, cur_valid);
    chk("m_busy1", busy1, cur_valid);
    chk("m_rdy0", rdy0, m_ready());
    chk("m_rdy1", rdy1, m_ready());
  endtask

  // One clock: inputs already driven; outputs checked 1 time unit after the edge.
  task automatic step();
    logic       xfer;
    logic [7:0] d;
    mbit_t      r;
    xfer = resetn && load_valid && m_ready();
    d    = din;
    @(posedge clk);
    #1;
    if (!resetn) begin
      model_clear();
    end else begin
      if (xfer)
        for (int unsigned p = 0; p < 8; p++) pend.push_back('{word: d, pos: p});
      if (pend.size() > 0) begin
        r = pend.pop_front();
        cur_valid = 1'b1;
        cur_word  = r.word;
        cur_pos   = r.pos;
      end else begin
        cur_valid = 1'b0;
      end
    end
    model_cmp();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_w0"}, w0, 1'b0);
    chk({nm, "_w1"}, w1, 1'b1);
    chk({nm, "_bv0"}, bv0, 1'b0);
    chk({nm, "_last0"}, lb0, 1'b0);
    chk({nm, "_busy0"}, busy0, 1'b0);
    chk({nm, "_busy1"}, busy1, 1'b0);
    chk({nm, "_rdy0"}, rdy0, 1'b1);
    chk({nm, "_rdy1"}, rdy1, 1'b1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    model_clear();
    chk_reset_vals("rst_now");
    step();
    resetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0]  a0;
    logic [15:0] pat;
    logic [7:0]  lseq;
    logic [3:0]  win;
    int          budget;

    // Table: single word A0, then back-to-back A5/5A.
    a0 = 8'hA0;
    tbl.push_back(mk(1'b1, 1'b1, 8'hA0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    for (int k = 1; k < 8; k++)
      tbl.push_back(mk(1'b1, 1'b0, 8'h00, a0[7-k], 1'b1, (k == 7), 1'b1, 1'b1, (k == 3)));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    pat = 16'hA55A;
    for (int k = 0; k < 16; k++)
      tbl.push_back(mk(1'b1, (k < 2), (k == 0) ? 8'hA5 : ((k == 1) ? 8'h5A : 8'h00),
                       pat[15-k], 1'b1, (k == 7 || k == 15), 1'b1, (k == 0 || k >= 8), 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

    #1 resetn = 1'b0;
    #1;
    chk_reset_vals("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    win = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      resetn = tbl[i].rn; load_valid = tbl[i].v; din = tbl[i].d;
      step();
      win = {win[2:0], w0};
      chk("tbl_w", w0, tbl[i].ew);
      chk("tbl_bv", bv0, tbl[i].ebv);
      chk("tbl_last", lb0, tbl[i].elb);
      chk("tbl_busy", busy0, tbl[i].ebusy);
      chk("tbl_rdy", rdy0, tbl[i].erdy);
      if (tbl[i].pat) chk4("det_1010", win, PAT_1010);
    end

    // Bypass: second word offered on the last-bit cycle of the first.
    din = 8'hC3; load_valid = 1'b1; step();
    load_valid = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("byp_last", lb0, 1'b1);
    chk("byp_lastw", w0, 1'b1);
    din = 8'h3C; load_valid = 1'b1; step();
    load_valid = 1'b0;
    chk("byp_bv", bv0, 1'b1);
    chk("byp_w", w0, 1'b0);
    chk("byp_rdy", rdy0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("byp_hold_empty", rdy0, 1'b1);
    end

    // Backpressure: hold full while the source keeps valid high with changing din.
    din = 8'h3C; load_valid = 1'b1; step();
    din = 8'h96; step();
    chk("bp_rdy_low", rdy0, 1'b0);
    budget = 20;
    while (!m_ready() && budget > 0) begin
      din = 8'($urandom); step(); budget--;
    end
    if (budget == 0) chk("bp_timeout", 1'b0, 1'b1);
    din = 8'h81; step();
    load_valid = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("bp_drained", busy0, 1'b0);

    // Reset mid-word with the hold slot full.
    din = 8'hFF; load_valid = 1'b1; step();
    din = 8'h77; step();
    load_valid = 1'b0;
    step(); step();
    chk("rmw_busy_before", busy0, 1'b1);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rmw_idle_w0", w0, 1'b0);
      chk("rmw_idle_bv", bv0, 1'b0);
    end

    // LSB-first, idle-high instance: 8'h05.
    lseq = 8'b1010_0000;
    din = 8'h05; load_valid = 1'b1; step();
    load_valid = 1'b0;
    chk("lsb_w_0", w1, lseq[7]);
    for (int k = 1; k < 8; k++) begin
      step();
      chk("lsb_w", w1, lseq[7-k]);
    end
    step();
    chk("lsb_idle_w", w1, 1'b1);
    chk("lsb_idle_bv", bv1, 1'b0);

    // Random traffic obeying the hold-until-accepted rule, with occasional resets.
    for (int c = 0; c < 500; c++) begin
      if (!(load_valid && !m_ready())) begin
        load_valid = ($urandom_range(9) < 6);
        din = 8'($urandom);
      end
      if ($urandom_range(149) == 0) do_reset();
      else step();
    end
    load_valid = 1'b0;
    for (int k = 0; k < 20; k++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
